pic_inta_sequencer: RTL and testbench

- CPU-facing end of the 8259 interrupt path.
- Consumes the pending-request vector from the IRQ request register, masks it and resolves priority (fully nested, IRQ0 highest).
- Drives INT to the CPU and runs the 8086-mode two-pulse INTA acknowledge.
- Returns the acknowledged index to the request register so it can clear its bit, and maintains the in-service register (ISR) until EOI.

---
 rtl/pic_pkg.sv | 26 ++
 rtl/pic_sync_edge.sv | 29 ++
 rtl/pic_inta_sequencer.sv | 128 ++++++++++++
 tb/tb_pic_inta_sequencer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// Shared types and helpers for the 8259 INTA path.
// PIC_AEOI_EN enables automatic EOI at the end of the second INTA pulse.
package pic_pkg;

   localparam int NUM_IRQ = 8;
   localparam logic [2:0] SPURIOUS_IDX = 3'd7;

   typedef enum logic [2:0] {
      IDLE,
      INT,
      ACK1,
      WAIT2,
      ACK2
   } pic_state_t;

   // Returns {valid, idx} of the lowest set bit (highest priority).
   function automatic logic [3:0] lowest_set_idx(input logic [7:0] v);
      logic [3:0] r;
      r = 4'd0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (v[i]) r = {1'b1, 3'(i)};
      end
      return r;
   endfunction

endpackage

// File: rtl/pic_sync_edge.sv
// Synchroniser with single-cycle rise/fall pulses for async strobes.
// Also suitable for wr/rd strobes.
module pic_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
         hist_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d};
         hist_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;
   assign fall = ~sync_q[SYNC_STAGES-1] & hist_q;

endmodule

// File: rtl/pic_inta_sequencer.sv
// Priority resolve, INT drive, 8086 two-pulse INTA and ISR upkeep.
// PIC_AEOI_EN adds the aeoi input (auto EOI on the second INTA fall).
module pic_inta_sequencer
   import pic_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] irq_status,
   input  logic [7:0] imr,
   input  logic [4:0] vector_base,
   input  logic       inta,
   input  logic       eoi,
   input  logic       eoi_specific,
   input  logic [2:0] eoi_level,
`ifdef PIC_AEOI_EN
   input  logic       aeoi,
`endif
   output logic       int_out,
   output logic       ack_valid,
   output logic [2:0] ack_idx,
   output logic [7:0] isr,
   output logic [7:0] data_out,
   output logic       data_oe
);

   pic_state_t state;
   logic [2:0] sel;
   logic       spurious;
   logic       inta_rise;
   logic       inta_fall;
   logic [7:0] req;
   logic [3:0] req_low;
   logic [3:0] isr_low;
   logic       cand_valid;
   logic [7:0] isr_set;
   logic [7:0] isr_clr;

   pic_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_inta_sync (
      .clk (clk),
      .rst (rst),
      .d   (inta),
      .rise(inta_rise),
      .fall(inta_fall)
   );

   always_comb begin
      req        = irq_status & ~imr;
      req_low    = lowest_set_idx(req);
      isr_low    = lowest_set_idx(isr);
      cand_valid = req_low[3] &&
                   (!isr_low[3] || req_low[2:0] < isr_low[2:0]);
      isr_set = '0;
      if (state == INT && inta_rise && cand_valid)
         isr_set[req_low[2:0]] = 1'b1;
      isr_clr = '0;
      if (eoi) begin
         if (eoi_specific) isr_clr[eoi_level] = 1'b1;
         else if (isr_low[3]) isr_clr[isr_low[2:0]] = 1'b1;
      end
`ifdef PIC_AEOI_EN
      if (aeoi && state == ACK2 && inta_fall && !spurious)
         isr_clr[sel] = 1'b1;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         int_out   <= 1'b0;
         ack_valid <= 1'b0;
         ack_idx   <= 3'd0;
         data_out  <= 8'd0;
         data_oe   <= 1'b0;
         sel       <= 3'd0;
         spurious  <= 1'b0;
         isr       <= 8'd0;
      end else begin
         ack_valid <= 1'b0;
         // a set wins over a same-cycle clear of the same bit
         isr <= (isr & ~isr_clr) | isr_set;
         unique case (state)
            IDLE: begin
               if (cand_valid) begin
                  int_out <= 1'b1;
                  state   <= INT;
               end
            end
            INT: begin
               if (inta_rise) begin
                  state <= ACK1;
                  if (cand_valid) begin
                     sel       <= req_low[2:0];
                     spurious  <= 1'b0;
                     ack_valid <= 1'b1;
                     ack_idx   <= req_low[2:0];
                  end else begin
                     sel      <= SPURIOUS_IDX;
                     spurious <= 1'b1;
                  end
               end
            end
            ACK1: begin
               if (inta_fall) state <= WAIT2;
            end
            WAIT2: begin
               if (inta_rise) begin
                  state    <= ACK2;
                  data_out <= {vector_base, sel};
                  data_oe  <= 1'b1;
               end
            end
            ACK2: begin
               if (inta_fall) begin
                  state   <= IDLE;
                  int_out <= 1'b0;
                  data_oe <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pic_inta_sequencer.sv
// Directed bench with an ack/vector scoreboard for pic_inta_sequencer.
module tb_pic_inta_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] irq_status;
   logic [7:0] imr;
   logic [4:0] vector_base;
   logic       inta;
   logic       eoi;
   logic       eoi_specific;
   logic [2:0] eoi_level;
`ifdef PIC_AEOI_EN
   logic       aeoi;
`endif
   logic       int_out;
   logic       ack_valid;
   logic [2:0] ack_idx;
   logic [7:0] isr;
   logic [7:0] data_out;
   logic       data_oe;

   int n_cmp = 0;
   int n_err = 0;
   int oe_cnt = 0;
   bit in_second = 1'b0;
   logic [7:0] exp_vec = 8'h00;
   logic [2:0] ack_q[$];

   always #5 clk = ~clk;

   pic_inta_sequencer #(.SYNC_STAGES(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .irq_status  (irq_status),
      .imr         (imr),
      .vector_base (vector_base),
      .inta        (inta),
      .eoi         (eoi),
      .eoi_specific(eoi_specific),
      .eoi_level   (eoi_level),
`ifdef PIC_AEOI_EN
      .aeoi        (aeoi),
`endif
      .int_out     (int_out),
      .ack_valid   (ack_valid),
      .ack_idx     (ack_idx),
      .isr         (isr),
      .data_out    (data_out),
      .data_oe     (data_oe)
   );

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && ack_valid) begin
         n_cmp++;
         assert (ack_q.size() > 0) else begin
            n_err++;
            $error("FAIL ack_unexpected observed=%0d expected=none",
                   ack_idx);
         end
         if (ack_q.size() > 0) chk("ack_idx", 8'(ack_idx),
                                   8'(ack_q.pop_front()));
      end
      if (!rst && data_oe) begin
         oe_cnt++;
         chk("oe_in_pulse2", 8'(in_second), 8'd1);
         chk("data_out", data_out, exp_vec);
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse(input bit second);
      in_second = second;
      inta = 1'b1;
      cyc(6);
      inta = 1'b0;
      cyc(6);
      in_second = 1'b0;
   endtask

   task automatic do_eoi(input bit spec, input logic [2:0] lvl);
      eoi = 1'b1;
      eoi_specific = spec;
      eoi_level = lvl;
      cyc(1);
      eoi = 1'b0;
      cyc(1);
   endtask

   initial begin
      rst = 1'b1;
      irq_status = 8'h00;
      imr = 8'h00;
      vector_base = 5'h08;
      inta = 1'b0;
      eoi = 1'b0;
      eoi_specific = 1'b0;
      eoi_level = 3'd0;
`ifdef PIC_AEOI_EN
      aeoi = 1'b0;
`endif
      cyc(2);
      chk("rst_int", 8'(int_out), 8'd0);
      chk("rst_isr", isr, 8'h00);
      chk("rst_oe", 8'(data_oe), 8'd0);
      chk("rst_data", data_out, 8'h00);
      rst = 1'b0;
      cyc(1);

      // basic two-pulse acknowledge of IRQ2
      irq_status = 8'h24;
      cyc(2);
      chk("t1_int", 8'(int_out), 8'd1);
      ack_q.push_back(3'd2);
      exp_vec = 8'h42;
      oe_cnt = 0;
      pulse(1'b0);
      chk("t1_isr_after_p1", isr, 8'h04);
      pulse(1'b1);
      chk("t1_oe_seen", 8'(oe_cnt > 0), 8'd1);
      chk("t1_isr", isr, 8'h04);
      chk("t1_int_low", 8'(int_out), 8'd0);

      // lower-priority request blocked by ISR, higher one nests
      irq_status = 8'h10;
      cyc(3);
      chk("t2_blocked", 8'(int_out), 8'd0);
      irq_status = 8'h01;
      cyc(2);
      chk("t2_int", 8'(int_out), 8'd1);
      ack_q.push_back(3'd0);
      exp_vec = 8'h40;
      pulse(1'b0);
      pulse(1'b1);
      chk("t2_isr", isr, 8'h05);

      // non-specific then specific EOI
      irq_status = 8'h00;
      do_eoi(1'b0, 3'd0);
      chk("eoi_ns", isr, 8'h04);
      do_eoi(1'b1, 3'd2);
      chk("eoi_sp", isr, 8'h00);

      // spurious: request vanishes before first INTA
      irq_status = 8'h08;
      cyc(2);
      chk("t3_int", 8'(int_out), 8'd1);
      irq_status = 8'h00;
      cyc(3);
      chk("t3_int_held", 8'(int_out), 8'd1);
      exp_vec = 8'h47;
      oe_cnt = 0;
      pulse(1'b0);
      pulse(1'b1);
      chk("t3_oe_seen", 8'(oe_cnt > 0), 8'd1);
      chk("t3_isr", isr, 8'h00);

      // EOI coincident with the ACK1 set of the same bit
      irq_status = 8'h04;
      cyc(2);
      ack_q.push_back(3'd2);
      exp_vec = 8'h42;
      inta = 1'b1;
      cyc(2);
      eoi = 1'b1;
      eoi_specific = 1'b1;
      eoi_level = 3'd2;
      cyc(1);
      eoi = 1'b0;
      chk("t4_set_wins", isr, 8'h04);
      cyc(3);
      inta = 1'b0;
      cyc(6);
      pulse(1'b1);
      chk("t4_isr", isr, 8'h04);
      irq_status = 8'h00;
      do_eoi(1'b1, 3'd2);
      chk("t4_eoi", isr, 8'h00);

      // reset during WAIT2, then restart
      irq_status = 8'h02;
      cyc(2);
      ack_q.push_back(3'd1);
      exp_vec = 8'h41;
      pulse(1'b0);
      chk("t5_isr_pre", isr, 8'h02);
      rst = 1'b1;
      #1;
      chk("t5_rst_int", 8'(int_out), 8'd0);
      chk("t5_rst_isr", isr, 8'h00);
      chk("t5_rst_oe", 8'(data_oe), 8'd0);
      cyc(1);
      rst = 1'b0;
      cyc(3);
      chk("t5_reint", 8'(int_out), 8'd1);
      ack_q.push_back(3'd1);
      pulse(1'b0);
      pulse(1'b1);
      chk("t5_isr", isr, 8'h02);
      irq_status = 8'h00;
`ifdef PIC_AEOI_EN
      do_eoi(1'b0, 3'd0);
      chk("t6_pre", isr, 8'h00);
      aeoi = 1'b1;
      irq_status = 8'h02;
      cyc(2);
      ack_q.push_back(3'd1);
      pulse(1'b0);
      irq_status = 8'h00;
      chk("t6_isr_set", isr, 8'h02);
      pulse(1'b1);
      chk("t6_aeoi", isr, 8'h00);
`else
      do_eoi(1'b0, 3'd0);
      chk("t6_eoi", isr, 8'h00);
`endif

      chk("q_empty", 8'(ack_q.size()), 8'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
